mpuc_crot: RTL
==============

# mpuc_crot

Time-multiplexed complex constant multiplier for the FFT256 datapath, generalised from the fixed single-constant rotator. A complex sample (DR, DI) is multiplied by one of four runtime-selectable real constants using shift-add (CSD) arithmetic, with an optional −j post-rotation. Real and imaginary parts share one multiplier on consecutive enabled cycles. It sits between butterfly stages wherever a twiddle of angle π/4 or π/8 is applied.

## Interface
- nb, 12, input data width; outputs are nb+1 bits
- CLK  in  1  clock, rising edge
- RST  in  1  reset, synchronous, active-high
- EI  in  1  clock enable; when 0 all state holds
- ED  in  1  data strobe; DR/DI/SEL/MPYJ sampled when EI=1 and ED=1
- MPYJ  in  1  multiply result by −j
- SEL  in  2  coefficient select: 0=cos(π/4), 1=cos(π/8), 2=sin(π/8), 3=cos(π/8)+sin(π/8)
- DR  in  nb  real input, signed
- DI  in  nb  imaginary input, signed
- DOR  out  nb+1  real output, signed
- DOI  out  nb+1  imaginary output, signed
- RDY  out  1  one-enabled-cycle pulse, DOR/DOI new

## Operation
- Clock: one clock CLK; reset RST is synchronous and active-high.
- Product: P = floor(X·K / 2^16), two's-complement arithmetic shift (truncation toward −∞).
- K per SEL, high precision: 46341, 60547, 25080, 85627.
- K per SEL, low precision: 256·{181, 237, 98, 334}.
- Sampling: on ED, DR enters the multiplier and DI is held; on the next enabled cycle the held DI enters.
- SEL and MPYJ are captured with ED and travel with the sample.
- Output without MPYJ: DOR=P(DR), DOI=P(DI).
- Output with MPYJ: DOR=P(DI), DOI=−P(DR).
- Width: |P| < 2^nb, so negation never overflows nb+1 bits; no saturation logic.
- ED spacing: ED on back-to-back enabled cycles is legal. The second ED wins, the first sample is discarded, and no RDY is produced for it.
- Reset values: DOR=0, DOI=0, RDY=0, all pipeline valid flags cleared, held DI=0.

## Timing
- Latency: ED accepted at enabled edge t gives DOR/DOI/RDY updated at enabled edge t+4.
- Stages: capture; real multiply; imaginary multiply with real-result hold; output register.
- RDY is high exactly one enabled cycle per accepted sample. DOR/DOI hold their values until the next RDY.
- EI=0 freezes every stage including RDY, so latency counts enabled edges only.
- Throughput: one complex sample per 2 enabled cycles.
- RST mid-operation: all in-flight samples are lost; no RDY until a new ED has passed 4 enabled edges after reset release.
- RST and ED asserted on the same edge: reset wins and the sample is dropped.

## Configuration
- FFT256_COEF_HIGH_EN defined: high-precision 16-bit-fraction constants (extra CSD terms).
- FFT256_COEF_HIGH_EN undefined: low-precision 8-bit-fraction constants (fewer adders).
- Latency and interface are identical in both builds.

## Structure
- Package fft_mpuc_pkg holds:
  - SEL encoding constants
  - both coefficient sets as localparams
  - the fraction width (16)
- Sub-module mpuc_csd_mul: combinational or single-register shift-add multiply of one nb-bit signed operand by the SEL-chosen constant. It is instantiated once and time-shared.

## Test plan
- Basic multiply: nb=12, SEL=0, DR=1024, DI=0, MPYJ=0 → four enabled cycles later DOR=724, DOI=0, RDY pulse. Same result in both builds.
- −j rotation: SEL=1, DR=1024, DI=512, MPYJ=1, high build → DOR=473, DOI=−946.
- Negative extreme: SEL=3, DR=−2048, DI=2047.
  - High build: DOR=−2676, DOI=2674.
  - Low build: DOR=−2672, DOI=2670.
- Stall: ED then EI=0 for 3 cycles → RDY appears after 4 enabled edges (7 clocks); outputs match the unstalled run.
- Back-to-back ED: samples A then B on consecutive enabled cycles → exactly one RDY, carrying B's result.
- Reset mid-flight: RST pulsed two cycles after ED → outputs 0, no RDY. The next sample after release completes normally at +4.

Source files
------------

// File: rtl/mpuc_crot_pkg.sv
// ============================================================================
// Module : fft_mpuc_pkg
// Brief  : Shared definitions for the mpuc_crot complex constant multiplier.
//          It holds the coefficient-select encoding, both coefficient sets
//          (as K scaled by 2^16) and the common fraction width.
// Config : FFT256_COEF_HIGH_EN selects which set coef_k() returns.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fft_mpuc_pkg;

  // Encoding of the coefficient select input
  typedef enum logic [1:0] {
    SEL_COS_PI4 = 2'd0,   // cos(pi/4)
    SEL_COS_PI8 = 2'd1,   // cos(pi/8)
    SEL_SIN_PI8 = 2'd2,   // sin(pi/8)
    SEL_SUM_PI8 = 2'd3    // cos(pi/8) + sin(pi/8)
  } sel_e;

  // Every product is X*K / 2^COEF_FRAC, whichever precision is built
  localparam int COEF_FRAC = 16;

  // 16-bit-fraction constants
  localparam int unsigned COEF_HIGH [4] = '{46341, 60547, 25080, 85627};

  // 8-bit-fraction constants, pre-scaled onto the 16-bit fraction grid
  localparam int unsigned COEF_LOW  [4] = '{181 * 256, 237 * 256, 98 * 256, 334 * 256};

  // Constant applied by the active build for a given select
  function automatic int unsigned coef_k(input sel_e sel);
`ifdef FFT256_COEF_HIGH_EN
    return COEF_HIGH[int'(sel)];
`else
    return COEF_LOW[int'(sel)];
`endif
  endfunction

endpackage

`default_nettype wire

// File: rtl/mpuc_crot_if.sv
// ============================================================================
// Module : mpuc_crot_if
// Brief  : Sample/strobe bus of the mpuc_crot rotator.
//          master : drives EI, ED, MPYJ, SEL, DR, DI; receives DOR, DOI, RDY
//          slave  : the rotator side
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mpuc_crot_if #(
  parameter int NB = 12
);
  logic                 EI;    // clock enable
  logic                 ED;    // data strobe
  logic                 MPYJ;  // multiply result by -j
  logic [1:0]           SEL;   // coefficient select
  logic signed [NB-1:0] DR;    // real input
  logic signed [NB-1:0] DI;    // imaginary input
  logic signed [NB:0]   DOR;   // real output
  logic signed [NB:0]   DOI;   // imaginary output
  logic                 RDY;   // new output pulse

  modport master (
    output EI, ED, MPYJ, SEL, DR, DI,
    input  DOR, DOI, RDY
  );

  modport slave (
    input  EI, ED, MPYJ, SEL, DR, DI,
    output DOR, DOI, RDY
  );
endinterface

`default_nettype wire

// File: rtl/mpuc_csd_mul.sv
// ============================================================================
// Module : mpuc_csd_mul
// Brief  : Registered shift-add (CSD) multiply of one signed operand by the
//          selected constant: o_p = floor(i_x * K / 2^16).
// Ports  : clk, rst (sync, active-high), i_en (hold when low),
//          i_x (signed operand), i_sel (coefficient select),
//          o_p (registered signed product, NB+1 bits)
// Config : FFT256_COEF_HIGH_EN -> 16-bit-fraction constants, else 8-bit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mpuc_csd_mul
  import fft_mpuc_pkg::*;
#(
  parameter int NB = 12
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 i_en,
  input  wire logic signed [NB-1:0] i_x,
  input  wire logic [1:0]           i_sel,
  output logic signed [NB:0]        o_p
);

  // |X*K| < 2^(NB-1) * 1.31 * 2^16, so NB+17 bits hold the signed sum.
  // Partial sums may wrap; modular arithmetic still yields the exact total.
  localparam int W = NB + 17;

  logic signed [W-1:0] w_x;
  logic signed [W-1:0] w_acc;
  logic                w_unused_frac;

  assign w_x = {{(W-NB){i_x[NB-1]}}, i_x};

  always_comb begin
    w_acc = '0;
    case (sel_e'(i_sel))
`ifdef FFT256_COEF_HIGH_EN
      // 46341 = 2^15 + 2^14 - 2^12 + 2^10 + 2^8 + 2^2 + 2^0
      SEL_COS_PI4: w_acc = (w_x <<< 15) + (w_x <<< 14) - (w_x <<< 12)
                         + (w_x <<< 10) + (w_x <<< 8) + (w_x <<< 2) + w_x;
      // 60547 = 2^16 - 2^12 - 2^10 + 2^7 + 2^2 - 2^0
      SEL_COS_PI8: w_acc = (w_x <<< 16) - (w_x <<< 12) - (w_x <<< 10)
                         + (w_x <<< 7) + (w_x <<< 2) - w_x;
      // 25080 = 2^15 - 2^13 + 2^9 - 2^3
      SEL_SIN_PI8: w_acc = (w_x <<< 15) - (w_x <<< 13) + (w_x <<< 9)
                         - (w_x <<< 3);
      // 85627 = 2^16 + 2^14 + 2^12 - 2^8 - 2^7 - 2^2 - 2^0
      SEL_SUM_PI8: w_acc = (w_x <<< 16) + (w_x <<< 14) + (w_x <<< 12)
                         - (w_x <<< 8) - (w_x <<< 7) - (w_x <<< 2) - w_x;
`else
      // 181*256 = 2^15 + 2^14 - 2^12 + 2^10 + 2^8
      SEL_COS_PI4: w_acc = (w_x <<< 15) + (w_x <<< 14) - (w_x <<< 12)
                         + (w_x <<< 10) + (w_x <<< 8);
      // 237*256 = 2^16 - 2^12 - 2^10 + 2^8
      SEL_COS_PI8: w_acc = (w_x <<< 16) - (w_x <<< 12) - (w_x <<< 10)
                         + (w_x <<< 8);
      // 98*256 = 2^15 - 2^13 + 2^9
      SEL_SIN_PI8: w_acc = (w_x <<< 15) - (w_x <<< 13) + (w_x <<< 9);
      // 334*256 = 2^16 + 2^14 + 2^12 - 2^9
      SEL_SUM_PI8: w_acc = (w_x <<< 16) + (w_x <<< 14) + (w_x <<< 12)
                         - (w_x <<< 9);
`endif
      default: w_acc = '0;
    endcase
  end

  // Dropping the fraction bits of a two's-complement value is floor()
  assign w_unused_frac = ^w_acc[COEF_FRAC-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      o_p <= '0;
    end else if (i_en) begin
      o_p <= w_acc[W-1:COEF_FRAC];
    end
  end

endmodule

`default_nettype wire

// File: rtl/mpuc_crot.sv
// ============================================================================
// Module : mpuc_crot
// Brief  : Time-multiplexed complex-by-real-constant multiplier with optional
//          -j post-rotation. One shared CSD multiplier handles the real part
//          and then the imaginary part on consecutive enabled cycles.
// Ports  : CLK, RST (sync, active-high), bus (mpuc_crot_if.slave):
//          EI enable, ED strobe, MPYJ, SEL, DR, DI in; DOR, DOI, RDY out.
// Config : FFT256_COEF_HIGH_EN selects high-precision constants (in the
//          multiplier); latency and interface do not change.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mpuc_crot
  import fft_mpuc_pkg::*;
#(
  parameter int NB = 12
) (
  input  wire logic   CLK,
  input  wire logic   RST,
  mpuc_crot_if.slave  bus
);

  // Stage valids: v1 captured, v2 real product ready, v3 imag product ready,
  // v4 both products aligned for the output register.
  logic                 r_v1, r_v2, r_v3, r_v4;
  logic                 r_j1, r_j2, r_j3, r_j4;
  logic signed [NB-1:0] r_dr;
  logic signed [NB-1:0] r_dih;
  logic [1:0]           r_sel;
  logic signed [NB:0]   r_pr;
  logic signed [NB:0]   r_pi;
  logic signed [NB:0]   r_dor;
  logic signed [NB:0]   r_doi;
  logic                 r_rdy;

  logic signed [NB-1:0] w_op;
  logic signed [NB:0]   w_prod;

  // The cycle after capture feeds DR; the cycle after that (r_v2) feeds the
  // held DI. r_sel stays valid for both, since a new capture in between
  // would have killed the older sample anyway.
  assign w_op = r_v2 ? r_dih : r_dr;

  mpuc_csd_mul #(
    .NB (NB)
  ) u_mul (
    .clk   (CLK),
    .rst   (RST),
    .i_en  (bus.EI),
    .i_x   (w_op),
    .i_sel (r_sel),
    .o_p   (w_prod)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_v3  <= 1'b0;
      r_v4  <= 1'b0;
      r_j1  <= 1'b0;
      r_j2  <= 1'b0;
      r_j3  <= 1'b0;
      r_j4  <= 1'b0;
      r_dr  <= '0;
      r_dih <= '0;
      r_sel <= '0;
      r_pr  <= '0;
      r_pi  <= '0;
      r_dor <= '0;
      r_doi <= '0;
      r_rdy <= 1'b0;
    end else if (bus.EI) begin
      // Capture
      if (bus.ED) begin
        r_dr  <= bus.DR;
        r_dih <= bus.DI;
        r_sel <= bus.SEL;
        r_j1  <= bus.MPYJ;
      end
      r_v1 <= bus.ED;

      // A strobe right behind a captured sample supersedes it
      r_v2 <= r_v1 & ~bus.ED;
      r_v3 <= r_v2;
      r_v4 <= r_v3;

      // MPYJ rides along; spacing of at least 2 keeps it aligned
      r_j2 <= r_j1;
      r_j3 <= r_j2;
      r_j4 <= r_j3;

      // Real product lands one cycle before the imaginary one; hold it
      if (r_v2) r_pr <= w_prod;
      if (r_v3) r_pi <= w_prod;

      // Output register with optional -j: (a + jb)(-j) = b - ja
      r_rdy <= r_v4;
      if (r_v4) begin
        r_dor <= r_j4 ? r_pi  : r_pr;
        r_doi <= r_j4 ? -r_pr : r_pi;
      end
    end
  end

  assign bus.DOR = r_dor;
  assign bus.DOI = r_doi;
  assign bus.RDY = r_rdy;

endmodule

`default_nettype wire
